// File: rtl/td4_sequencer.sv
// rtl/td4_sequencer.sv - TD4 fetch/decode/execute sequencer with PC, carry flag and ROM-timeout fault
module td4_sequencer #(
  parameter int ROM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  output logic [3:0] rom_addr,
  output logic       rom_req,
  input  logic       rom_ack,
  input  logic [7:0] rom_data,
  output logic [7:0] dec_op,
  output logic       dec_carry,
  input  logic [1:0] dec_sel,
  input  logic [3:0] dec_load,
  input  logic       alu_carry,
  output logic [1:0] alu_sel,
  output logic [3:0] imm,
  output logic [2:0] reg_we,
  output logic       busy,
  output logic       fault,
  output logic [7:0] instr_count
);

  localparam int CW = $clog2(ROM_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [3:0]    pc_q, pc_d;
  logic [7:0]    ir_q, ir_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    load_q, load_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [7:0]    cnt_q, cnt_d;

  // Next-state and datapath update for the instruction cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    sel_d   = sel_q;
    load_d  = load_q;
    carry_d = carry_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (run || step) begin
          state_d = S_FETCH;
          tmo_d   = '0;
        end
      end
      S_FETCH: begin
        // An ack arriving on the last allowed cycle still counts as a fetch.
        if (rom_ack) begin
          ir_d    = rom_data;
          state_d = S_DECODE;
        end else if (tmo_q == CW'(ROM_TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DECODE: begin
        sel_d   = dec_sel;
        load_d  = dec_load;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        carry_d = alu_carry;
        pc_d    = load_q[3] ? ir_q[3:0] : pc_q + 4'd1;
        cnt_d   = cnt_q + 8'd1;
        if (run) begin
          state_d = S_FETCH;
          tmo_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      sel_q   <= '0;
      load_q  <= '0;
      carry_q <= 1'b0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      carry_q <= carry_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode; decoder inputs come straight from flops so they never glitch
  always_comb begin
    rom_addr    = pc_q;
    rom_req     = (state_q == S_FETCH);
    dec_op      = ir_q;
    dec_carry   = carry_q;
    alu_sel     = sel_q;
    imm         = ir_q[3:0];
    reg_we      = (state_q == S_EXEC) ? load_q[2:0] : 3'b000;
    busy        = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    fault       = (state_q == S_FAULT);
    instr_count = cnt_q;
  end

endmodule

// File: tb/tb_td4_sequencer.sv
// tb/tb_td4_sequencer.sv - directed self-checking bench for td4_sequencer
module tb_td4_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, step;
  logic [3:0] rom_addr;
  logic       rom_req, rom_ack;
  logic [7:0] rom_data;
  logic [7:0] dec_op;
  logic       dec_carry;
  logic [1:0] dec_sel;
  logic [3:0] dec_load;
  logic       alu_carry;
  logic [1:0] alu_sel;
  logic [3:0] imm;
  logic [2:0] reg_we;
  logic       busy, fault;
  logic [7:0] instr_count;

  logic       ack_en;
  logic [7:0] rom [16];
  int         checks = 0;
  int         errors = 0;

  td4_sequencer #(.ROM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
    .dec_op(dec_op), .dec_carry(dec_carry), .dec_sel(dec_sel), .dec_load(dec_load),
    .alu_carry(alu_carry), .alu_sel(alu_sel), .imm(imm), .reg_we(reg_we),
    .busy(busy), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];
  assign rom_ack  = rom_req & ack_en;

  // Minimal TD4 decoder model
  always_comb begin
    dec_sel  = 2'b00;
    dec_load = 4'b0001;
    case (dec_op[7:4])
      4'b0011: begin dec_sel = 2'b11; dec_load = 4'b0001; end
      4'b0111: begin dec_sel = 2'b11; dec_load = 4'b0010; end
      4'b1011: begin dec_sel = 2'b11; dec_load = 4'b0100; end
      4'b1111: begin dec_sel = 2'b11; dec_load = 4'b1000; end
      4'b1110: begin dec_sel = 2'b11; dec_load = dec_carry ? 4'b0000 : 4'b1000; end
      default: begin dec_sel = 2'b00; dec_load = 4'b0001; end
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0]  = 8'h33;  // MOV A,3
    rom[1]  = 8'hFA;  // JMP 10
    rom[10] = 8'h05;  // ADD A,5
    rom[11] = 8'hE0;  // JNC 0
    rom[12] = 8'hFF;  // JMP 15
    rom[15] = 8'h01;  // ADD A,1
    rst = 1'b1; run = 1'b0; step = 1'b0; ack_en = 1'b1; alu_carry = 1'b0;

    cyc(2);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_req", 8'(rom_req), 8'h00);
    chk("rst_fault", 8'(fault), 8'h00);
    chk("rst_we", 8'(reg_we), 8'h00);
    chk("rst_cnt", instr_count, 8'h00);
    chk("rst_addr", 8'(rom_addr), 8'h00);
    chk("rst_op", dec_op, 8'h00);
    chk("rst_carry", 8'(dec_carry), 8'h00);

    // Free run: MOV A,3
    rst = 1'b0; run = 1'b1;
    cyc(1);
    chk("f0_req", 8'(rom_req), 8'h01);
    chk("f0_addr", 8'(rom_addr), 8'h00);
    cyc(1);
    chk("d0_op", dec_op, 8'h33);
    chk("d0_we", 8'(reg_we), 8'h00);
    cyc(1);
    chk("e0_we", 8'(reg_we), 8'h01);
    chk("e0_sel", 8'(alu_sel), 8'h03);
    chk("e0_imm", 8'(imm), 8'h03);
    cyc(1);
    chk("f1_addr", 8'(rom_addr), 8'h01);
    chk("f1_cnt", instr_count, 8'h01);
    // JMP 10
    cyc(1);
    chk("d1_op", dec_op, 8'hFA);
    cyc(1);
    chk("e1_we", 8'(reg_we), 8'h00);
    cyc(1);
    chk("jmp_addr", 8'(rom_addr), 8'h0A);
    chk("jmp_cnt", instr_count, 8'h02);
    // ADD with carry-out, then JNC not taken
    cyc(2);
    alu_carry = 1'b1;
    cyc(1);
    alu_carry = 1'b0;
    chk("f11_addr", 8'(rom_addr), 8'h0B);
    cyc(1);
    chk("jnc_op", dec_op, 8'hE0);
    chk("jnc_carry", 8'(dec_carry), 8'h01);
    cyc(1);
    chk("jnc_we", 8'(reg_we), 8'h00);
    cyc(1);
    chk("jnc_addr", 8'(rom_addr), 8'h0C);
    chk("carry_reload", 8'(dec_carry), 8'h00);
    // JMP 15, then PC wrap 15->0
    cyc(3);
    chk("f15_addr", 8'(rom_addr), 8'h0F);
    cyc(3);
    chk("wrap_addr", 8'(rom_addr), 8'h00);
    chk("wrap_cnt", instr_count, 8'h06);

    // Drop run mid-instruction
    run = 1'b0;
    cyc(2);
    chk("drop_busy", 8'(busy), 8'h01);
    chk("drop_we", 8'(reg_we), 8'h01);
    cyc(1);
    chk("drop_idle", 8'(busy), 8'h00);
    chk("drop_addr", 8'(rom_addr), 8'h01);
    chk("drop_cnt", instr_count, 8'h07);
    cyc(1);
    chk("idle_hold", 8'(busy), 8'h00);

    // Single step; a second step while busy is ignored
    step = 1'b1;
    cyc(1);
    chk("step_req", 8'(rom_req), 8'h01);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(1);
    chk("step_exec", 8'(busy), 8'h01);
    cyc(1);
    chk("step_idle", 8'(busy), 8'h00);
    chk("step_addr", 8'(rom_addr), 8'h0A);
    chk("step_cnt", instr_count, 8'h08);
    cyc(1);
    chk("step_ignored", 8'(busy), 8'h00);

    // instr_count wrap 255->0
    run = 1'b1;
    cyc(742);
    chk("cnt_255", instr_count, 8'hFF);
    cyc(3);
    chk("cnt_wrap", instr_count, 8'h00);
    run = 1'b0;
    cyc(3);
    chk("cnt_idle", 8'(busy), 8'h00);

    // Ack on the 4th FETCH cycle: no fault
    ack_en = 1'b0; step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(3);
    chk("late_req", 8'(rom_req), 8'h01);
    chk("late_nofault", 8'(fault), 8'h00);
    ack_en = 1'b1;
    cyc(1);
    chk("late_decode", 8'(busy), 8'h01);
    chk("late_req_off", 8'(rom_req), 8'h00);
    chk("late_fault", 8'(fault), 8'h00);
    ack_en = 1'b0;
    cyc(2);
    chk("late_idle", 8'(busy), 8'h00);

    // No ack: FAULT after the 4th FETCH cycle, sticky
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(3);
    chk("to_req4", 8'(rom_req), 8'h01);
    chk("to_nofault4", 8'(fault), 8'h00);
    cyc(1);
    chk("to_fault", 8'(fault), 8'h01);
    chk("to_busy", 8'(busy), 8'h00);
    chk("to_req", 8'(rom_req), 8'h00);
    run = 1'b1; step = 1'b1; ack_en = 1'b1;
    cyc(5);
    chk("to_sticky", 8'(fault), 8'h01);
    chk("to_we", 8'(reg_we), 8'h00);
    chk("to_req_sticky", 8'(rom_req), 8'h00);
    step = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_clears_fault", 8'(fault), 8'h00);

    // Reset mid-FETCH returns to IDLE with pc=0
    @(negedge clk);
    rst = 1'b0; run = 1'b1; ack_en = 1'b1;
    cyc(3);
    ack_en = 1'b0;
    cyc(1);
    chk("mid_addr", 8'(rom_addr), 8'h01);
    cyc(1);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", 8'(busy), 8'h00);
    chk("mid_req", 8'(rom_req), 8'h00);
    chk("mid_pc", 8'(rom_addr), 8'h00);
    chk("mid_cnt", instr_count, 8'h00);
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    cyc(2);
    chk("post_idle", 8'(busy), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
